// File: rtl/vlsu_shf_scheduler.sv
// vlsu_shf_scheduler: accepts VLSU load descriptors, computes the per-request
// beat count, issues one meta record per request to the shuffle unit, and
// tracks outstanding requests in order, counting per-lane VRF write acks
// against the head request's beat count before reporting completion.
module vlsu_shf_scheduler #(
    parameter int NrLanes        = 4,
    parameter int DLEN           = 64,
    parameter int VlBits         = 16,
    parameter int ReqIdBits      = 4,
    parameter int MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    // request descriptor from the control machine
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [ReqIdBits-1:0] req_id_i,
    input  logic [VlBits-1:0]    req_vl_i,
    input  logic [VlBits-1:0]    req_vstart_i,
    input  logic [1:0]           req_sew_i,
    input  logic [5:0]           req_vd_i,
    input  logic                 req_vm_i,
    input  logic [1:0]           req_mode_i,
    // meta record to the shuffle unit
    output logic                 meta_valid_o,
    input  logic                 meta_ready_i,
    output logic [ReqIdBits-1:0] meta_id_o,
    output logic [VlBits-1:0]    meta_vstart_o,
    output logic [1:0]           meta_sew_o,
    output logic [5:0]           meta_vd_o,
    output logic                 meta_vm_o,
    output logic [1:0]           meta_mode_o,
    output logic [VlBits-1:0]    meta_cmtcnt_o,
    // per-lane VRF write acknowledgements
    input  logic [NrLanes-1:0]   lane_ack_valid_i,
    output logic [NrLanes-1:0]   lane_ack_ready_o,
    // in-order completion back to the control machine
    output logic                 done_valid_o,
    output logic [ReqIdBits-1:0] done_id_o,
    input  logic                 done_ready_i,
    output logic                 busy_o
);

    // Bytes moved per beat across all lanes; assumed a power of two.
    localparam int BB    = NrLanes * DLEN / 8;
    localparam int BbLog = $clog2(BB);
    localparam int PtrW  = $clog2(MaxOutstanding);
    // Beat counts and lane counters carry one extra bit over vl.
    localparam int BeatW = VlBits + 1;
    // (vl - vstart) << sew needs up to three extra bits.
    localparam int ByteW = VlBits + 3;
    // One more bit so the ceil-rounding add cannot overflow.
    localparam int SumW  = ByteW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE
    } state_e;

    state_e state_q;

    // Descriptor latched at accept, consumed in CALC.
    logic [ReqIdBits-1:0] lat_id;
    logic [VlBits-1:0]    lat_vl;
    logic [VlBits-1:0]    lat_vstart;
    logic [1:0]           lat_sew;
    logic [5:0]           lat_vd;
    logic                 lat_vm;
    logic [1:0]           lat_mode;

    // Beat computation from the latched descriptor.
    logic [VlBits-1:0] diff_w;
    logic [ByteW-1:0]  bytes_w;
    logic [SumW-1:0]   sum_w;
    logic [BeatW-1:0]  beats_w;

    // Tracker storage and flag+value pointers.
    logic [ReqIdBits-1:0] trk_id_q    [MaxOutstanding];
    logic [BeatW-1:0]     trk_beats_q [MaxOutstanding];
    logic [PtrW:0]        wr_ptr_q;
    logic [PtrW:0]        rd_ptr_q;
    logic                 trk_full;
    logic                 trk_empty;
    logic                 push;
    logic                 pop;
    logic [ReqIdBits-1:0] head_id;
    logic [BeatW-1:0]     head_beats;

    // Per-lane ack counters for the head request.
    logic [BeatW-1:0] cnt_q [NrLanes];
    logic             all_done;

    assign trk_full   = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) &&
                        (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
    assign trk_empty  = (wr_ptr_q == rd_ptr_q);
    assign head_id    = trk_id_q[rd_ptr_q[PtrW-1:0]];
    assign head_beats = trk_beats_q[rd_ptr_q[PtrW-1:0]];

    assign req_ready_o = (state_q == ST_IDLE) && !trk_full;
    assign push        = (state_q == ST_CALC);
    assign pop         = done_valid_o && done_ready_i;

    // Beats = ceil(((vl - vstart) << sew) / BB), zero when vl <= vstart.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        diff_w = '0;
        if (lat_vl > lat_vstart) begin
            diff_w = lat_vl - lat_vstart;
        end
        bytes_w = {3'b000, diff_w} << lat_sew;
        sum_w   = {1'b0, bytes_w} + SumW'(BB - 1);
        beats_w = BeatW'(sum_w >> BbLog);
    end

    // Lane ready and head completion are judged against the head entry only.
    always_comb begin
        lane_ack_ready_o = '0;
        all_done         = !trk_empty && !done_valid_o;
        for (int l = 0; l < NrLanes; l++) begin
            lane_ack_ready_o[l] = !trk_empty && (cnt_q[l] < head_beats) && !done_valid_o;
            if (cnt_q[l] != head_beats) begin
                all_done = 1'b0;
            end
        end
    end

    // Issue FSM: accept, compute beats, present the meta record.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            lat_id        <= '0;
            lat_vl        <= '0;
            lat_vstart    <= '0;
            lat_sew       <= '0;
            lat_vd        <= '0;
            lat_vm        <= 1'b0;
            lat_mode      <= '0;
            meta_valid_o  <= 1'b0;
            meta_id_o     <= '0;
            meta_vstart_o <= '0;
            meta_sew_o    <= '0;
            meta_vd_o     <= '0;
            meta_vm_o     <= 1'b0;
            meta_mode_o   <= '0;
            meta_cmtcnt_o <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of order.
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        lat_id     <= req_id_i;
                        lat_vl     <= req_vl_i;
                        lat_vstart <= req_vstart_i;
                        lat_sew    <= req_sew_i;
                        lat_vd     <= req_vd_i;
                        lat_vm     <= req_vm_i;
                        lat_mode   <= req_mode_i;
                        state_q    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    meta_id_o     <= lat_id;
                    meta_vstart_o <= lat_vstart;
                    meta_sew_o    <= lat_sew;
                    meta_vd_o     <= lat_vd;
                    meta_vm_o     <= lat_vm;
                    meta_mode_o   <= lat_mode;
                    meta_cmtcnt_o <= VlBits'(beats_w - BeatW'(1));
                    if (beats_w == '0) begin
                        // Zero-length request: tracked for completion only.
                        state_q <= ST_IDLE;
                    end else begin
                        meta_valid_o <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (meta_ready_i) begin
                        meta_valid_o <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Tracker payload written at the push slot.
    always_ff @(posedge clk_i) begin
        // NOTE: the payload array has no reset; the pointers alone define
        // which entries are valid, so stale contents are never observed.
        if (push) begin
            trk_id_q[wr_ptr_q[PtrW-1:0]]    <= lat_id;
            trk_beats_q[wr_ptr_q[PtrW-1:0]] <= beats_w;
        end
    end

    // Tracker pointers; the extra MSB toggles on each wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Lane counters: count accepted acks, clear when the head retires.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int l = 0; l < NrLanes; l++) begin
                cnt_q[l] <= '0;
            end
        end else if (pop) begin
            for (int l = 0; l < NrLanes; l++) begin
                cnt_q[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NrLanes; l++) begin
                if (lane_ack_valid_i[l] && lane_ack_ready_o[l]) begin
                    cnt_q[l] <= cnt_q[l] + 1'b1;
                end
            end
        end
    end

    // Completion register: raised once all lanes reach the head beat count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_valid_o <= 1'b0;
            done_id_o    <= '0;
        end else if (pop) begin
            done_valid_o <= 1'b0;
        end else if (all_done) begin
            done_valid_o <= 1'b1;
            done_id_o    <= head_id;
        end
    end

    // Busy flag, registered from the current FSM, tracker and done state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o <= 1'b0;
        end else begin
            busy_o <= (state_q != ST_IDLE) || !trk_empty || done_valid_o;
        end
    end

endmodule

// File: doc/vlsu_shf_scheduler.md
Name: vlsu_shf_scheduler

Overview:
- Sits between the VLSU control machine and the shuffle unit.
- Accepts load-request descriptors and computes the per-request beat count (cmtCnt). Issues one meta-info record per request to the shuffle unit's meta interface.
- Tracks outstanding requests in order. Counts per-lane VRF write acknowledgements against each request's beat count and reports in-order completion back to the control machine.

Parameters:
NrLanes, 4, number of lanes; power of two.
DLEN, 64, per-lane datapath width in bits; beat bytes BB = NrLanes*DLEN/8.
VlBits, 16, width of vl/vstart.
ReqIdBits, 4, request id width.
MaxOutstanding, 4, tracker queue depth; power of two, >=2.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  request descriptor valid
req_ready_o  out  1  request accepted when valid&&ready
req_id_i  in  ReqIdBits  request id
req_vl_i  in  VlBits  vector length (elements)
req_vstart_i  in  VlBits  start element
req_sew_i  in  2  element width, 0=8b..3=64b
req_vd_i  in  6  destination register (passed through)
req_vm_i  in  1  unmasked when 1 (passed through)
req_mode_i  in  2  addressing mode (passed through)
meta_valid_o  out  1  meta record valid to shuffle unit
meta_ready_i  in  1  shuffle unit meta ready
meta_id_o  out  ReqIdBits  id
meta_vstart_o  out  VlBits  vstart
meta_sew_o  out  2  sew
meta_vd_o  out  6  vd
meta_vm_o  out  1  vm
meta_mode_o  out  2  mode
meta_cmtcnt_o  out  VlBits  beats minus one
lane_ack_valid_i  in  NrLanes  lane l wrote one beat
lane_ack_ready_o  out  NrLanes  lane l ack accepted
done_valid_o  out  1  head request complete
done_id_o  out  ReqIdBits  completed id
done_ready_i  in  1  completion consumed
busy_o  out  1  any request in flight

Behaviour:
- Reset (async, rst_i=1): FSM=IDLE; tracker empty; all lane counters 0. req_ready_o=1 is a combinational consequence of this state.
- Reset drives every registered output to 0: meta_valid_o, done_valid_o, busy_o and all meta_* data fields.
- Reset mid-operation discards all in-flight state; no done is reported for lost requests.
- Beat computation: bytes = (vl-vstart) << sew, computed at VlBits+3 width.
  - beats = ceil(bytes/BB).
  - If vl<=vstart then beats=0.
  - meta_cmtcnt_o = beats-1, truncated to VlBits.
- Issue FSM states: IDLE, CALC, ISSUE.
  - IDLE: req_ready_o = !tracker_full. On accept, latch the descriptor and go to CALC.
  - CALC (1 cycle): register beats. Push {id, beats} into the tracker this cycle. Tracker space is guaranteed because it was checked at accept.
    - If beats==0, go to IDLE; no meta record is issued.
    - Otherwise go to ISSUE.
  - ISSUE: meta_valid_o=1 with stable fields until meta_ready_i. On handshake, go to IDLE.
  - Minimum accept-to-accept spacing: 3 cycles for nonzero requests, 2 cycles for zero-length requests.
- Tracker: circular queue with flag+value pointers.
  - full = values equal and flags differ.
  - empty = values equal and flags equal.
  - Pointers wrap at MaxOutstanding with the flag toggled.
- Lane counting applies to the head entry only. Per-lane counter cnt[l] has VlBits+1 bits.
  - lane_ack_ready_o[l] = !empty && cnt[l] < head.beats && !done_valid_o.
  - An accepted ack increments cnt[l].
  - A lane that finishes early is back-pressured until the head retires.
- Completion:
  - When the tracker is not empty, every cnt[l]==head.beats, and done_valid_o=0: register done_valid_o=1 and done_id_o=head.id on the next cycle.
  - This includes beats==0, which completes one cycle after the push.
  - On done handshake: pop the tracker, clear all cnt[l], drop done_valid_o. The next head is evaluated on the following cycle.
- Simultaneous push (CALC) and pop (done handshake) in the same cycle are both performed; the occupancy count is unchanged.
- busy_o (registered) = FSM!=IDLE || !tracker_empty || done_valid_o.
- Acks arriving while the tracker is empty are not accepted (ready=0).

Test Plan:
- NrLanes=4, DLEN=64 (BB=32); vl=64, sew=2, vstart=0 -> meta_cmtcnt_o=7 two cycles after accept. Then 8 acks per lane -> done_id_o = req id, done_valid_o=1 one cycle after the 8th ack on the last lane.
- vl=10, sew=0, vstart=3 -> 7 bytes -> meta_cmtcnt_o=0. One ack per lane completes the request.
- vl=5, vstart=5 -> no meta_valid_o. done_valid_o=1 two cycles after accept (push in CALC, done registered one cycle later).
- Issue 4 requests (ids 1..4) with no acks -> req_ready_o=0 while 4 are outstanding.
  - Complete id 1 -> req_ready_o=1 the next cycle.
  - Ids complete in order 1,2,3,4; pointer wrap is verified by 3 further requests.
- Lane 0 sends 3 acks early for a 2-beat head -> lane_ack_ready_o[0]=0 after 2 accepted acks. The third ack is accepted only after the head retires and counts toward the next request.
- Assert rst_i while in ISSUE with 2 requests outstanding -> meta_valid_o=0, done_valid_o=0, busy_o=0 immediately; req_ready_o=1 after release.
